md_sched: RTL
=============

// Module: md_sched
// PURPOSE
// - Sequencing controller for multi-cycle MULT/MULTU/DIV/DIVU issued from EX.
// - Accepts one op at a time, steps the iterative md_core datapath 1 bit per cycle, and holds the pipeline via stallreq_for_md.
// - Presents the 64-bit {hi,lo} result for the EX->MEM hi/lo write path.
// - Sits beside EX; its stall request feeds the pipeline stall controller.
// PARAMETERS
// - DW      32  operand width; result is 2*DW ({hi,lo})
// - CNT_W    6  iteration counter width; must satisfy 2^CNT_W > DW
// PORTS
// - clk             in   1     clock
// - rst             in   1     reset: asynchronous, active-high
// - start_i         in   1     EX holds a mult/div op; held high while stalled
// - op_i            in   4     {mult,multu,div,divu}, one-hot (low 4 bits of hilo_op)
// - opdata1_i       in   DW    rs value: multiplicand / dividend
// - opdata2_i       in   DW    rt value: multiplier / divisor
// - cancel_i        in   1     flush: abandon the current op
// - hold_i          in   1     downstream stall: keep the DONE result
// - stallreq_for_md out  1     stop IF..EX while the op is unfinished
// - ready_o         out  1     hi_o/lo_o valid this cycle
// - hi_o            out  DW    HI result (product high / remainder)
// - lo_o            out  DW    LO result (product low / quotient)
// BEHAVIOUR
// - Reset (async, any state): state=IDLE, cnt=0, ready_o=0, hi_o=lo_o=0, stallreq_for_md=0.
// - States: IDLE, BUSY, DONE (encodings in defines.vh).
// - IDLE
//   - start_i & op_i!=0 & ~cancel_i: latch operands and op, cnt=0.
//   - Next state is BUSY, or DONE when (div|divu) & opdata2_i==0.
//   - stallreq_for_md = start_i & |op_i & ~cancel_i, combinational in the same cycle.
// - Signed ops: operands are converted to magnitude at latch time.
//   - Product and quotient sign = sign1^sign2.
//   - Remainder sign = dividend sign.
//   - Negation is applied once, on the transition into DONE.
// - BUSY: one md_core step per cycle, cnt++.
//   - At cnt==DW-1, move to DONE; the final result is registered on that edge.
//   - stallreq_for_md=1 for every BUSY cycle.
// - Latency: DW+1 stall cycles (33 at DW=32) from accept to the first DONE cycle.
// - DONE: ready_o=1, hi_o/lo_o valid, stallreq_for_md=0, so EX advances this cycle.
//   - hold_i=1: stay in DONE with outputs stable.
//   - Otherwise: go to IDLE next cycle; ready_o drops and hi_o/lo_o are held, not cleared.
//   - start_i seen in DONE is not a new op. A new op is accepted only in IDLE, earliest 1 cycle after DONE.
// - Divide by zero: 1-cycle stall, then DONE with lo_o=32'hFFFF_FFFF and hi_o=opdata1_i (team-defined value).
// - cancel_i has priority over every event, in any state.
//   - Next state IDLE, cnt=0, ready_o=0.
//   - Combinationally forces stallreq_for_md=0.
//   - cancel_i and start_i together in IDLE: the op is not accepted.
// - Width rules
//   - Multiply: 2*DW unsigned shift-add accumulator.
//   - Divide: restoring division, DW+1-bit partial remainder.
//   - Counter stops at DW-1; no wrap.
// - An op_i value that is not one-hot is treated as no op.
// STRUCTURE
// - defines.vh (shared): `MD_IDLE/`MD_BUSY/`MD_DONE state codes; op one-hot bit indices; `Stop/`NoStop.
// - Sub-module md_core
//   - Pure datapath: accumulator/remainder registers plus one step of shift-add or shift-subtract.
//   - Controls: load, step, is_div.
//   - md_sched owns the FSM, the counter, sign fix-up, divide-by-zero and cancel.
// TESTING
// - multu FFFFFFFF*00000002
//   - stall for 33 cycles, then ready_o with hi=00000001, lo=FFFFFFFE.
// - mult FFFFFFFD(-3)*00000005
//   - hi=FFFFFFFF, lo=FFFFFFF1.
//   - hold_i=1 for 3 cycles in DONE: outputs and ready_o stay stable.
// - div FFFFFFF9(-7)/00000002
//   - lo=FFFFFFFD, hi=FFFFFFFF.
// - divu 00000064/00000007
//   - lo=0000000E, hi=00000002.
//   - A back-to-back second op is accepted only after the IDLE cycle.
// - divu 00001234/00000000
//   - exactly 1 stall cycle, then lo=FFFFFFFF, hi=00001234.
// - cancel_i at BUSY cnt=10
//   - next cycle IDLE, ready_o=0, stall=0.
//   - A following mult 6*7 gives lo=0000002A, hi=0.
//   - rst pulsed mid-BUSY gives all outputs 0 immediately.

Source files
------------

// File: rtl/md_sched_pkg.sv
// Shared types for the multiply/divide sequencer: FSM states and op one-hot bit positions.
package md_sched_pkg;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

  // op_i is {mult, multu, div, divu}
  localparam int unsigned OP_DIVU  = 0;
  localparam int unsigned OP_DIV   = 1;
  localparam int unsigned OP_MULTU = 2;
  localparam int unsigned OP_MULT  = 3;

  function automatic logic op_valid(input logic [3:0] op);
    return $onehot(op);
  endfunction

endpackage

// File: rtl/md_sched_core.sv
// Iterative unsigned datapath: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle.
module md_sched_core #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          step,
  input  logic          is_div,
  input  logic [DW-1:0] opa,
  input  logic [DW-1:0] opb,
  output logic [DW-1:0] nxt_hi,
  output logic [DW-1:0] nxt_lo
);
  import md_sched_pkg::*;

  logic [2*DW-1:0] acc;
  logic [DW:0]     rem;
  logic [DW-1:0]   opnd;

  logic [DW:0]     sum;
  logic [2*DW-1:0] acc_mul_nxt;
  logic [DW:0]     shifted;
  logic            ge;
  logic [DW:0]     rem_nxt;
  logic [DW-1:0]   quot_nxt;

  // nxt_hi/nxt_lo expose the post-step value so the final result can be registered on the last step edge
  always_comb begin
    sum         = {1'b0, acc[2*DW-1:DW]} + (acc[0] ? {1'b0, opnd} : '0);
    acc_mul_nxt = {sum, acc[DW-1:1]};
    shifted     = {rem[DW-1:0], acc[DW-1]};
    ge          = (shifted >= {1'b0, opnd});
    rem_nxt     = ge ? (shifted - {1'b0, opnd}) : shifted;
    quot_nxt    = {acc[DW-2:0], ge};
    if (is_div) begin
      nxt_hi = rem_nxt[DW-1:0];
      nxt_lo = quot_nxt;
    end else begin
      nxt_hi = acc_mul_nxt[2*DW-1:DW];
      nxt_lo = acc_mul_nxt[DW-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc  <= '0;
      rem  <= '0;
      opnd <= '0;
    end else if (load) begin
      opnd <= is_div ? opb : opa;
      acc  <= is_div ? {{DW{1'b0}}, opa} : {{DW{1'b0}}, opb};
      rem  <= '0;
    end else if (step) begin
      if (is_div) begin
        acc <= {acc[2*DW-1:DW], quot_nxt};
        rem <= rem_nxt;
      end else begin
        acc <= acc_mul_nxt;
      end
    end
  end

endmodule

// File: rtl/md_sched.sv
// Sequencing controller for MULT/MULTU/DIV/DIVU: FSM, iteration count, sign fix-up, divide-by-zero and cancel.
module md_sched #(
  parameter int DW    = 32,
  parameter int CNT_W = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic [3:0]    op_i,
  input  logic [DW-1:0] opdata1_i,
  input  logic [DW-1:0] opdata2_i,
  input  logic          cancel_i,
  input  logic          hold_i,
  output logic          stallreq_for_md,
  output logic          ready_o,
  output logic [DW-1:0] hi_o,
  output logic [DW-1:0] lo_o
);
  import md_sched_pkg::*;

  md_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic             div_r, neg_q, neg_r;

  logic             req, accept, op_div, op_signed, s1, s2, dz;
  logic [DW-1:0]    mag1, mag2, core_hi, core_lo, res_hi, res_lo;
  logic [2*DW-1:0]  prod;

  always_comb begin
    req       = start_i & op_valid(op_i);
    accept    = (state == MD_IDLE) & req & ~cancel_i;
    op_div    = op_i[OP_DIV] | op_i[OP_DIVU];
    op_signed = op_i[OP_DIV] | op_i[OP_MULT];
    s1        = op_signed & opdata1_i[DW-1];
    s2        = op_signed & opdata2_i[DW-1];
    mag1      = s1 ? (~opdata1_i + 1'b1) : opdata1_i;
    mag2      = s2 ? (~opdata2_i + 1'b1) : opdata2_i;
    dz        = op_div & (opdata2_i == '0);
    stallreq_for_md = ~cancel_i & ((state == MD_BUSY) | ((state == MD_IDLE) & req));
  end

  md_sched_core #(.DW(DW)) u_core (
    .clk    (clk),
    .rst    (rst),
    .load   (accept),
    .step   ((state == MD_BUSY) & ~cancel_i),
    .is_div (accept ? op_div : div_r),
    .opa    (mag1),
    .opb    (mag2),
    .nxt_hi (core_hi),
    .nxt_lo (core_lo)
  );

  // Multiply negates the full 2*DW product; divide negates quotient and remainder independently
  always_comb begin
    prod = {core_hi, core_lo};
    if (neg_q) prod = ~prod + 1'b1;
    if (div_r) begin
      res_lo = neg_q ? (~core_lo + 1'b1) : core_lo;
      res_hi = neg_r ? (~core_hi + 1'b1) : core_hi;
    end else begin
      res_hi = prod[2*DW-1:DW];
      res_lo = prod[DW-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= MD_IDLE;
      cnt     <= '0;
      div_r   <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      ready_o <= 1'b0;
      hi_o    <= '0;
      lo_o    <= '0;
    end else if (cancel_i) begin
      state   <= MD_IDLE;
      cnt     <= '0;
      ready_o <= 1'b0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (accept) begin
            cnt   <= '0;
            div_r <= op_div;
            neg_q <= s1 ^ s2;
            neg_r <= op_div & s1;
            if (dz) begin
              state   <= MD_DONE;
              ready_o <= 1'b1;
              hi_o    <= opdata1_i;
              lo_o    <= '1;
            end else begin
              state <= MD_BUSY;
            end
          end
        end
        MD_BUSY: begin
          if (cnt == CNT_W'(DW - 1)) begin
            state   <= MD_DONE;
            ready_o <= 1'b1;
            hi_o    <= res_hi;
            lo_o    <= res_lo;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        MD_DONE: begin
          if (!hold_i) begin
            state   <= MD_IDLE;
            ready_o <= 1'b0;
          end
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

endmodule
